weight_buffer_writer: RTL and testbench
=======================================

Name: weight_buffer_writer

Overview:
Upstream feeder for the weight double buffer (DATA_WIDTH 64, BANK_DEPTH 288).
- Accepts a narrow weight stream over valid/ready and packs it into 64-bit words.
- Writes one full tile into the write bank: wen/wadr/wdata, addresses 0..BANK_DEPTH-1.
- Then issues a one-cycle switch_banks pulse once the downstream reader has released the other bank.
- Sits between the off-chip weight input stream and the double buffer's write port and switch_banks input.

Parameters:
IN_WIDTH, 16, input stream beat width; DATA_WIDTH must be an integer multiple of it.
DATA_WIDTH, 64, buffer word width.
BANK_ADDR_WIDTH, 10, buffer address width.
BANK_DEPTH, 288, words per tile (IC0*OC0*FX*FY*IC1).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous, active-high reset (1 = reset), sampled on clk rising edge.
in_data  in  IN_WIDTH  weight beat.
in_valid  in  1  beat valid.
in_ready  out  1  block accepts a beat this cycle.
reader_done  in  1  one-cycle pulse from the consumer: it has finished the current read bank.
wen  out  1  buffer write enable.
wadr  out  BANK_ADDR_WIDTH  buffer write address.
wdata  out  DATA_WIDTH  buffer write data.
switch_banks  out  1  one-cycle bank swap pulse to the buffer.

Behaviour:
- PACK = DATA_WIDTH/IN_WIDTH (4 by default).
- Beat accepted when in_valid && in_ready.
- Beat k of a word (k = 0..PACK-1) goes to bits [k*IN_WIDTH +: IN_WIDTH], so beat 0 is in the LSBs.
- Reset values: in_ready=0, wen=0, wadr=0, wdata=0, switch_banks=0, beat count=0, word count=0, done_pending=0, first_tile=1, state=FILL.
- Reset mid-tile discards any partial word and all progress.
- FILL state:
  - in_ready=1.
  - On acceptance of beat PACK-1 at cycle t, at t+1: wen=1, wadr=word count, wdata=packed word. wen is high for exactly one cycle.
  - Word count then increments.
  - If that word was address BANK_DEPTH-1, state becomes WAIT_SWAP at t+1 and in_ready=0 from t+1.
- Throughput: one beat per cycle. Back-to-back words give wen every PACK cycles.
- WAIT_SWAP state:
  - in_ready=0.
  - Swap condition: first_tile || done_pending || reader_done.
  - When the condition holds, switch_banks=1 for exactly one cycle on the next cycle. In the same update, first_tile and done_pending clear, word count resets to 0, and state returns to FILL.
- switch_banks is never asserted in the same cycle as wen. The earliest swap is t+2 after the final beat.
- done_pending: a sticky latch. It is set by a reader_done pulse arriving in any state other than the cycle it is consumed by a swap.
- reader_done repeated before a swap: idempotent, at most one pending release.
- in_valid held low: state holds and outputs stay idle (wen=0).
- wadr and wdata hold their last values when wen=0.

Optional Feature:
Macro WEIGHT_WRITER_STALL_CNT_EN.
- Defined: adds output stall_cycles (32 bits), reset to 0. It increments in every cycle spent in WAIT_SWAP and saturates at all-ones.
- Undefined: no port and no logic.

Decomposition:
- Shared package weight_writer_pkg holds:
  - state enum {FILL, WAIT_SWAP}
  - localparam PACK
  - a BANK_DEPTH-1 constant for the last address
- One natural sub-module: weight_word_packer.
  - Contains the beat counter and shift/insert register.
  - Outputs word_valid and word.
- The top level keeps the address counter, FSM and swap handshake.

Test Plan:
1. Reset then 288*4 beats, in_valid always 1, beats = incrementing 16-bit values from 0 -> wen pulses 288 times. Word 0 = 64'h0003_0002_0001_0000, wadr runs 0..287. switch_banks pulses exactly once, 2 cycles after the final beat (first tile needs no reader_done).
2. Second tile with reader_done withheld -> after wadr 287, in_ready=0 and no switch_banks. Pulse reader_done 50 cycles later -> switch_banks pulses next cycle; with the macro, stall_cycles = 50 at that point.
3. reader_done pulsed at word 100 of tile 2 (early) -> switch_banks fires 2 cycles after the final beat, without further reader_done.
4. in_valid toggled 1/0 every cycle -> wen every 8 cycles, data still correctly packed. Tile completes at 288 words; no wen during idle.
5. rst_n=1 asserted after 2 beats of word 37 -> all outputs 0 next cycle. Restart writes the new word 0 at wadr 0; the first-tile swap rule applies again.
6. Check every cycle of tests 1-5 -> wen && switch_banks never both 1.

Source files
------------

// File: rtl/weight_writer_pkg.sv
// Shared definitions for the weight buffer writer: default geometry, state encoding, helpers.
// Optional feature macro: WEIGHT_WRITER_STALL_CNT_EN (adds the stall_cycles counter output).
package weight_writer_pkg;

    localparam int unsigned IN_WIDTH_DEF        = 16;
    localparam int unsigned DATA_WIDTH_DEF      = 64;
    localparam int unsigned BANK_ADDR_WIDTH_DEF = 10;
    localparam int unsigned BANK_DEPTH_DEF      = 288;

    // Beats per buffer word and the last word address of a tile, default geometry.
    localparam int unsigned PACK      = DATA_WIDTH_DEF / IN_WIDTH_DEF;
    localparam int unsigned LAST_ADDR = BANK_DEPTH_DEF - 1;

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } wr_state_e;

    // Beats per word for an arbitrary parameterisation.
    function automatic int unsigned pack_ratio(input int unsigned data_width,
                                               input int unsigned in_width);
        return data_width / in_width;
    endfunction

endpackage

// File: rtl/weight_word_packer.sv
// Packs PACK narrow beats into one buffer word, beat 0 in the LSBs.
// word_valid_c/word_c are combinational and flag the cycle the final beat is accepted.
module weight_word_packer
    import weight_writer_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = IN_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  beat_valid,
    input  logic [IN_WIDTH-1:0]   beat,
    output logic                  word_valid_c,
    output logic [DATA_WIDTH-1:0] word_c
);

    localparam int unsigned PACK_N = pack_ratio(DATA_WIDTH, IN_WIDTH);
    localparam int unsigned CNT_W  = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACK_N - 1);

    logic [CNT_W-1:0]      beat_cnt_q;
    logic [CNT_W-1:0]      beat_cnt_d;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;

    // Insert the accepted beat into its slot; the final beat bypasses the register into word_c.
    always_comb begin
        acc_d        = acc_q;
        beat_cnt_d   = beat_cnt_q;
        word_valid_c = 1'b0;
        word_c       = acc_q;
        word_c[(PACK_N-1)*IN_WIDTH +: IN_WIDTH] = beat;
        if (beat_valid) begin
            for (int unsigned k = 0; k < PACK_N; k++) begin
                if (beat_cnt_q == CNT_W'(k)) begin
                    acc_d[k*IN_WIDTH +: IN_WIDTH] = beat;
                end
            end
            if (beat_cnt_q == LAST_BEAT) begin
                word_valid_c = 1'b1;
                beat_cnt_d   = '0;
            end else begin
                beat_cnt_d   = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    // Beat counter and partial-word register; reset drops any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
        end
    end

endmodule

// File: rtl/weight_buffer_writer.sv
// Feeds the weight double buffer: packs the input stream into words, writes one tile into
// the write bank, then pulses switch_banks once the reader has released the other bank.
// Optional feature macro: WEIGHT_WRITER_STALL_CNT_EN (stall_cycles output, cycles in WAIT_SWAP).
// Note: rst_n is a synchronous, active-high reset despite its name.
module weight_buffer_writer
    import weight_writer_pkg::*;
#(
    parameter int unsigned IN_WIDTH        = IN_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int unsigned BANK_ADDR_WIDTH = BANK_ADDR_WIDTH_DEF,
    parameter int unsigned BANK_DEPTH      = BANK_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN_WIDTH-1:0]        in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       reader_done,
    output logic                       wen,
    output logic [BANK_ADDR_WIDTH-1:0] wadr,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic                       switch_banks
`ifdef WEIGHT_WRITER_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam logic [BANK_ADDR_WIDTH-1:0] LAST_WORD = BANK_ADDR_WIDTH'(BANK_DEPTH - 1);

    wr_state_e                  state_q;
    wr_state_e                  state_d;
    logic [BANK_ADDR_WIDTH-1:0] word_cnt_q;
    logic [BANK_ADDR_WIDTH-1:0] word_cnt_d;
    logic                       first_tile_q;
    logic                       first_tile_d;
    logic                       done_pending_q;
    logic                       done_pending_d;
    logic                       in_ready_d;
    logic                       wen_d;
    logic [BANK_ADDR_WIDTH-1:0] wadr_d;
    logic [DATA_WIDTH-1:0]      wdata_d;
    logic                       switch_banks_d;

    logic                       beat_accept_c;
    logic                       word_valid_c;
    logic [DATA_WIDTH-1:0]      word_c;

    assign beat_accept_c = in_valid && in_ready;

    weight_word_packer #(
        .IN_WIDTH   (IN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst_n),
        .beat_valid   (beat_accept_c),
        .beat         (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Next-state and registered-output logic for the fill / swap handshake.
    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        first_tile_d   = first_tile_q;
        done_pending_d = done_pending_q;
        in_ready_d     = in_ready;
        wen_d          = 1'b0;
        wadr_d         = wadr;
        wdata_d        = wdata;
        switch_banks_d = 1'b0;

        case (state_q)
            FILL: begin
                in_ready_d = 1'b1;
                if (reader_done) begin
                    done_pending_d = 1'b1;
                end
                if (word_valid_c) begin
                    wen_d      = 1'b1;
                    wadr_d     = word_cnt_q;
                    wdata_d    = word_c;
                    word_cnt_d = word_cnt_q + BANK_ADDR_WIDTH'(1);
                    if (word_cnt_q == LAST_WORD) begin
                        state_d    = WAIT_SWAP;
                        in_ready_d = 1'b0;
                    end
                end
            end
            WAIT_SWAP: begin
                in_ready_d = 1'b0;
                // The first tile has no previous reader to wait for; a same-cycle pulse also counts.
                if (first_tile_q || done_pending_q || reader_done) begin
                    switch_banks_d = 1'b1;
                    first_tile_d   = 1'b0;
                    done_pending_d = 1'b0;
                    word_cnt_d     = '0;
                    state_d        = FILL;
                    in_ready_d     = 1'b1;
                end
            end
            default: begin
                state_d    = FILL;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= FILL;
            word_cnt_q     <= '0;
            first_tile_q   <= 1'b1;
            done_pending_q <= 1'b0;
            in_ready       <= 1'b0;
            wen            <= 1'b0;
            wadr           <= '0;
            wdata          <= '0;
            switch_banks   <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            first_tile_q   <= first_tile_d;
            done_pending_q <= done_pending_d;
            in_ready       <= in_ready_d;
            wen            <= wen_d;
            wadr           <= wadr_d;
            wdata          <= wdata_d;
            switch_banks   <= switch_banks_d;
        end
    end

`ifdef WEIGHT_WRITER_STALL_CNT_EN
    // Saturating count of cycles spent waiting for the bank swap.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_cycles <= '0;
        end else if ((state_q == WAIT_SWAP) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_buffer_writer.sv
// Randomized bench for weight_buffer_writer against a beat/word/tile level reference model.
// Optional feature macro: WEIGHT_WRITER_STALL_CNT_EN (also checks stall_cycles).
module tb_weight_buffer_writer;

    localparam int unsigned IW    = 16;
    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 288;
    localparam int unsigned PACK  = DW / IW;
    localparam int          TILE_BEATS = DEPTH * PACK;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reader_done;
    logic          wen;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdata;
    logic          switch_banks;
`ifdef WEIGHT_WRITER_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    weight_buffer_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reader_done  (reader_done),
        .wen          (wen),
        .wadr         (wadr),
        .wdata        (wdata),
        .switch_banks (switch_banks)
`ifdef WEIGHT_WRITER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: beats collect into words, words fill a tile, a full tile waits for release.
    bit            model_on = 1'b0;
    logic [IW-1:0] m_beats[$];
    int            m_words;
    bit            m_full;
    bit            m_released;
    logic          e_wen;
    logic          e_sw;
    logic          e_ready;
    logic [AW-1:0] e_wadr;
    logic [DW-1:0] e_wdata;
    logic [31:0]   e_stall;

    int            wen_cnt;
    int            sw_cnt;
    logic [DW-1:0] first_word;
    bit            got_first;

    // Compare this cycle's outputs, then advance the model using this cycle's inputs.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (model_on) begin
            check("in_ready", 64'(in_ready), 64'(e_ready));
            check("wen", 64'(wen), 64'(e_wen));
            check("switch_banks", 64'(switch_banks), 64'(e_sw));
            check("wadr", 64'(wadr), 64'(e_wadr));
            check("wdata", wdata, e_wdata);
            check("wen_with_swap", 64'(wen & switch_banks), 64'd0);
`ifdef WEIGHT_WRITER_STALL_CNT_EN
            check("stall_cycles", 64'(stall_cycles), 64'(e_stall));
`endif
        end
        if (wen === 1'b1) wen_cnt++;
        if (switch_banks === 1'b1) sw_cnt++;
        if (wen === 1'b1 && wadr == '0 && !got_first) begin
            first_word = wdata;
            got_first  = 1'b1;
        end

        if (rst_n === 1'b1) begin
            model_on   = 1'b1;
            m_beats.delete();
            m_words    = 0;
            m_full     = 1'b0;
            m_released = 1'b1;
            e_wen      = 1'b0;
            e_sw       = 1'b0;
            e_ready    = 1'b0;
            e_wadr     = '0;
            e_wdata    = '0;
            e_stall    = '0;
        end else if (model_on) begin
            e_wen = 1'b0;
            e_sw  = 1'b0;
            if (m_full) begin
                if (e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 32'd1;
                if (m_released || reader_done) begin
                    e_sw       = 1'b1;
                    m_full     = 1'b0;
                    m_words    = 0;
                    m_released = 1'b0;
                end
            end else begin
                if (reader_done) m_released = 1'b1;
                if (in_valid && e_ready) begin
                    m_beats.push_back(in_data);
                    if (m_beats.size() == PACK) begin
                        w = '0;
                        for (int k = 0; k < int'(PACK); k++) begin
                            w = w | (DW'(m_beats[k]) << (k * IW));
                        end
                        m_beats.delete();
                        e_wen   = 1'b1;
                        e_wadr  = AW'(m_words);
                        e_wdata = w;
                        m_words++;
                        if (m_words == int'(DEPTH)) m_full = 1'b1;
                    end
                end
            end
            e_ready = !m_full;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid    = 1'b0;
        reader_done = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_counts();
        wen_cnt   = 0;
        sw_cnt    = 0;
        got_first = 1'b0;
    endtask

    // mode 0: incrementing data; 1: random data; 2: random data with in_valid toggling.
    // rd_at >= 0 pulses reader_done in the cycle after that many beats were accepted.
    task automatic feed(input int n, input int mode, input int rd_at);
        int       acc = 0;
        int       cyc = 0;
        bit       sent = 1'b0;
        bit       accepted;
        logic [IW-1:0] seq = '0;
        while (acc < n && cyc < 20000) begin
            in_valid    = (mode == 2) ? (cyc % 2 == 0) : 1'b1;
            in_data     = (mode == 0) ? seq : IW'($urandom);
            reader_done = 1'b0;
            if (rd_at >= 0 && acc == rd_at && !sent) begin
                reader_done = 1'b1;
                sent        = 1'b1;
            end
            accepted = in_valid && in_ready;
            tick();
            if (accepted) begin
                acc++;
                seq = seq + IW'(1);
            end
            cyc++;
        end
        check("feed_beats", 64'(acc), 64'(n));
        in_valid    = 1'b0;
        reader_done = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        reader_done = 1'b0;
        clear_counts();
        repeat (3) tick();
        rst_n = 1'b0;

        // Tile 1: incrementing data, first tile swaps without reader_done.
        clear_counts();
        feed(TILE_BEATS, 0, -1);
        idle(10);
        check("t1_wen_count", 64'(wen_cnt), 64'd288);
        check("t1_swaps", 64'(sw_cnt), 64'd1);
        check("t1_word0", first_word, 64'h0003_0002_0001_0000);

        // Tile 2: reader_done withheld, then released 50 cycles later.
        clear_counts();
        feed(TILE_BEATS, 1, -1);
        idle(50);
        check("t2_no_swap", 64'(sw_cnt), 64'd0);
        check("t2_ready_low", 64'(in_ready), 64'd0);
        reader_done = 1'b1;
        tick();
        reader_done = 1'b0;
        idle(5);
        check("t2_swaps", 64'(sw_cnt), 64'd1);
        check("t2_wen_count", 64'(wen_cnt), 64'd288);

        // Tile 3: early release at word 100.
        clear_counts();
        feed(TILE_BEATS, 1, 400);
        idle(5);
        check("t3_swaps", 64'(sw_cnt), 64'd1);

        // Tile 4: in_valid toggling, no release.
        clear_counts();
        feed(TILE_BEATS, 2, -1);
        idle(5);
        check("t4_wen_count", 64'(wen_cnt), 64'd288);
        check("t4_no_swap", 64'(sw_cnt), 64'd0);

        // Reset mid-word 37, then a fresh first tile.
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        clear_counts();
        feed(37 * int'(PACK) + 2, 1, -1);
        rst_n = 1'b1;
        tick();
        check("t5_rst_wen", 64'(wen), 64'd0);
        check("t5_rst_wadr", 64'(wadr), 64'd0);
        check("t5_rst_wdata", wdata, 64'd0);
        check("t5_rst_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        clear_counts();
        feed(TILE_BEATS, 1, -1);
        idle(5);
        check("t5_wen_count", 64'(wen_cnt), 64'd288);
        check("t5_swaps", 64'(sw_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
